// File: rtl/flopoco_to_ieee_stream.sv
// flopoco_to_ieee_stream: FloPoCo FP to IEEE-754 stream converter with output FIFO; FLOPOCO2IEEE_FLAGS_EN adds {nan,inf,zero} flags
module flopoco_to_ieee_stream #(
  parameter int DataWidth = 32,
  parameter int Depth     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DataWidth+1:0] in_fp_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_data_o
`ifdef FLOPOCO2IEEE_FLAGS_EN
  ,
  output logic [2:0]           out_flags_o
`endif
);
  localparam int E  = (DataWidth == 16) ? 5 : 8;
  localparam int M  = DataWidth - 1 - E;
  localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CW = $clog2(Depth + 1);
  if (!(DataWidth == 16 || DataWidth == 32)) begin : g_bad_width
    $error("flopoco_to_ieee_stream: DataWidth must be 16 or 32");
  end
  if (Depth < 1) begin : g_bad_depth
    $error("flopoco_to_ieee_stream: Depth must be >= 1");
  end
  logic [1:0]           exn;
  logic                 sgn;
  logic [DataWidth-1:0] conv;
  logic [DataWidth-1:0] mem [Depth];
  logic [PW-1:0]        rd_ptr, wr_ptr;
  logic [CW-1:0]        count;
  logic                 push, pop;
  assign exn  = in_fp_i[DataWidth+1:DataWidth];
  assign sgn  = in_fp_i[DataWidth-1];
  assign conv = (exn == 2'b00) ? {sgn, {(DataWidth-1){1'b0}}} :
                (exn == 2'b01) ? in_fp_i[DataWidth-1:0] :
                (exn == 2'b10) ? {sgn, {E{1'b1}}, {M{1'b0}}} :
                                 {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
  assign in_ready_o  = !rst_i && (count != CW'(Depth));
  assign out_valid_o = (count != '0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign out_data_o  = out_valid_o ? mem[rd_ptr] : '0;
  // Storage carries no reset; emptiness is tracked by count alone.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= conv;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(Depth - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop) rd_ptr <= (rd_ptr == PW'(Depth - 1)) ? '0 : rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
`ifdef FLOPOCO2IEEE_FLAGS_EN
  logic [2:0] flag_mem [Depth];
  always_ff @(posedge clk_i) begin
    if (push) flag_mem[wr_ptr] <= {exn == 2'b11, exn == 2'b10, exn == 2'b00};
  end
  assign out_flags_o = out_valid_o ? flag_mem[rd_ptr] : '0;
`endif
  a_in_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (in_valid_i && !in_ready_o) |=> $stable(in_fp_i))
    else $warning("in_fp_i changed while stalled");
  a_count_max: assert property (@(posedge clk_i) count <= CW'(Depth));
endmodule

// File: tb/tb_flopoco_to_ieee_stream.sv
// tb_flopoco_to_ieee_stream: randomized and directed checks of both widths against a queue-based reference model
module tb_flopoco_to_ieee_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic        a_iv, a_ir, a_ov, a_or;
  logic [33:0] a_fp;
  logic [31:0] a_d;
  logic        b_iv, b_ir, b_ov, b_or;
  logic [17:0] b_fp;
  logic [15:0] b_d;
`ifdef FLOPOCO2IEEE_FLAGS_EN
  logic [2:0]  a_fl, b_fl;
`endif
  int n_checks = 0;
  int n_pass = 0;
  int pushes_a = 0, pops_a = 0, pushes_b = 0, pops_b = 0;
  logic [34:0] qa [$];
  logic [34:0] qb [$];

  flopoco_to_ieee_stream #(.DataWidth(32), .Depth(2)) u_a (
    .clk_i(clk), .rst_i(rst), .in_valid_i(a_iv), .in_ready_o(a_ir), .in_fp_i(a_fp),
    .out_valid_o(a_ov), .out_ready_i(a_or), .out_data_o(a_d)
`ifdef FLOPOCO2IEEE_FLAGS_EN
    , .out_flags_o(a_fl)
`endif
  );
  flopoco_to_ieee_stream #(.DataWidth(16), .Depth(1)) u_b (
    .clk_i(clk), .rst_i(rst), .in_valid_i(b_iv), .in_ready_o(b_ir), .in_fp_i(b_fp),
    .out_valid_o(b_ov), .out_ready_i(b_or), .out_data_o(b_d)
`ifdef FLOPOCO2IEEE_FLAGS_EN
    , .out_flags_o(b_fl)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Returns {flags, ieee value} from the numeric meaning of each exception code.
  function automatic logic [34:0] ref_entry(input int w, input logic [1:0] exn, input logic [31:0] raw);
    int e = (w == 16) ? 5 : 8;
    int m = w - 1 - e;
    logic [31:0] s = (raw >> (w - 1)) & 32'd1;
    logic [31:0] inf_mag = ((32'd1 << e) - 32'd1) << m;
    case (exn)
      2'b00:   return {3'b001, s << (w - 1)};
      2'b01:   return {3'b000, raw};
      2'b10:   return {3'b010, (s << (w - 1)) | inf_mag};
      default: return {3'b100, inf_mag | (32'd1 << (m - 1))};
    endcase
  endfunction

  always @(negedge clk) begin
    logic [34:0] exp;
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      if (a_iv && a_ir) begin
        qa.push_back(ref_entry(32, a_fp[33:32], a_fp[31:0]));
        pushes_a++;
      end
      if (a_ov && a_or) begin
        pops_a++;
        if (qa.size() == 0) check("a_underflow", 64'(qa.size()), 64'd1);
        else begin
          exp = qa.pop_front();
          check("a_data", 64'(a_d), 64'(exp[31:0]));
`ifdef FLOPOCO2IEEE_FLAGS_EN
          check("a_flags", 64'(a_fl), 64'(exp[34:32]));
`endif
        end
      end
      if (b_iv && b_ir) begin
        qb.push_back(ref_entry(16, b_fp[17:16], {16'b0, b_fp[15:0]}));
        pushes_b++;
      end
      if (b_ov && b_or) begin
        pops_b++;
        if (qb.size() == 0) check("b_underflow", 64'(qb.size()), 64'd1);
        else begin
          exp = qb.pop_front();
          check("b_data", 64'(b_d), 64'(exp[31:0]));
`ifdef FLOPOCO2IEEE_FLAGS_EN
          check("b_flags", 64'(b_fl), 64'(exp[34:32]));
`endif
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [33:0] fps [3];
    logic [31:0] exps [3];
    logic [2:0]  fls [3];
    logic [33:0] pa, pb, pc, px;
    int p0, q0;
    logic r;
    fps  = '{34'h0_FFFF_FFFF, 34'h2_8000_1234, 34'h3_8123_4567};
    exps = '{32'h8000_0000, 32'hFF80_0000, 32'h7FC0_0000};
    fls  = '{3'b001, 3'b010, 3'b100};
    a_iv = 0; a_or = 0; a_fp = '0;
    b_iv = 0; b_or = 0; b_fp = '0;
    step();
    step();
    check("rst_a_ready", 64'(a_ir), 64'd0);
    check("rst_a_valid", 64'(a_ov), 64'd0);
    check("rst_a_data", 64'(a_d), 64'd0);
    check("rst_b_ready", 64'(b_ir), 64'd0);
    rst = 0;
    #1;
    check("post_rst_ready", 64'(a_ir), 64'd1);
    check("post_rst_valid", 64'(a_ov), 64'd0);
    // 1.0 passes through with one cycle of latency
    a_fp = 34'h1_3F80_0000; a_iv = 1; a_or = 1;
    step();
    a_iv = 0;
    check("one_valid", 64'(a_ov), 64'd1);
    check("one_data", 64'(a_d), 64'h3F80_0000);
    step();
    check("one_gone", 64'(a_ov), 64'd0);
    for (int i = 0; i < 3; i++) begin
      a_fp = fps[i]; a_iv = 1;
      step();
      a_iv = 0;
      check("exn_data", 64'(a_d), 64'(exps[i]));
`ifdef FLOPOCO2IEEE_FLAGS_EN
      check("exn_flags", 64'(a_fl), 64'(fls[i]));
`endif
      step();
    end
    // Backpressure: third beat must be held off until a pop
    pa = {2'b01, 32'($urandom)}; pb = {2'b01, 32'($urandom)}; pc = {2'b01, 32'($urandom)};
    p0 = pops_a;
    a_or = 0; a_fp = pa; a_iv = 1;
    step();
    check("bp_ready1", 64'(a_ir), 64'd1);
    a_fp = pb;
    step();
    check("bp_full", 64'(a_ir), 64'd0);
    a_fp = pc;
    step();
    check("bp_held", 64'(a_ir), 64'd0);
    check("bp_head", 64'(a_d), 64'(pa[31:0]));
    a_or = 1;
    step();
    check("bp_ready_back", 64'(a_ir), 64'd1);
    step();
    a_iv = 0;
    step();
    step();
    check("bp_pops", 64'(pops_a - p0), 64'd3);
    check("bp_drained", 64'(qa.size()), 64'd0);
    // Full-rate random traffic
    p0 = pops_a;
    a_iv = 1; a_or = 1;
    for (int i = 0; i < 100; i++) begin
      a_fp = {2'($urandom_range(0, 3)), 32'($urandom)};
      step();
      check("rnd_ready", 64'(a_ir), 64'd1);
    end
    a_iv = 0;
    step();
    step();
    check("rnd_pops", 64'(pops_a - p0), 64'd100);
    // Reset with a full FIFO discards buffered beats
    a_or = 0; a_iv = 1;
    a_fp = {2'($urandom_range(0, 3)), 32'($urandom)};
    step();
    a_fp = {2'($urandom_range(0, 3)), 32'($urandom)};
    step();
    a_iv = 0;
    check("pre_rst_full", 64'(a_ir), 64'd0);
    rst = 1;
    #1;
    check("rst_ready_low", 64'(a_ir), 64'd0);
    step();
    rst = 0;
    check("rst_mid_valid", 64'(a_ov), 64'd0);
    check("rst_mid_data", 64'(a_d), 64'd0);
    p0 = pops_a;
    px = {2'b01, 32'($urandom)};
    a_fp = px; a_iv = 1; a_or = 1;
    step();
    a_iv = 0;
    check("rst_new_data", 64'(a_d), 64'(px[31:0]));
    step();
    step();
    check("rst_new_pops", 64'(pops_a - p0), 64'd1);
    check("rst_new_empty", 64'(a_ov), 64'd0);
    // binary16, single-entry FIFO
    b_fp = {2'b01, 16'h3C00}; b_iv = 1; b_or = 1;
    step();
    b_iv = 0;
    check("h_one", 64'(b_d), 64'h3C00);
    step();
    b_fp = {2'b11, 16'hFFFF}; b_iv = 1;
    step();
    b_iv = 0;
    check("h_nan", 64'(b_d), 64'h7E00);
    step();
    p0 = pops_b; q0 = pushes_b;
    b_fp = {2'($urandom_range(0, 3)), 16'($urandom)}; b_iv = 1;
    for (int i = 0; i < 20; i++) begin
      r = b_ir;
      step();
      if (r) b_fp = {2'($urandom_range(0, 3)), 16'($urandom)};
    end
    b_iv = 0;
    step();
    step();
    check("h_tp_pushes", 64'(pushes_b - q0), 64'd10);
    check("h_tp_pops", 64'(pops_b - p0), 64'd10);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
